// File: rtl/servo_pwm_gen.sv
// -----------------------------------------------------------------------------
// servo_pwm_gen
//   Fixed-period servo pulse generator. Each period begins at a "period start
//   edge" (PSE). At that edge the pulse width is latched from the position
//   code, so the width only changes on period boundaries and the output never
//   glitches. A settle counter raises `ready` once the same width has been
//   held for SETTLE_PERIODS complete periods.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high
//   ENABLE       in   run request; checked in IDLE and at the terminal count
//   grados[1:0]  in   position code: 0 = 0 deg, 1 = +90, 2 = -90, 3 = error
//   pwm          out  registered servo pulse
//   period_tick  out  one-cycle strobe in the first cycle of every period
//   ready        out  position settled
// -----------------------------------------------------------------------------
module servo_pwm_gen #(
  parameter int PERIOD_CYCLES  = 2_000_000,
  parameter int PULSE_NEG90    = 100_000,
  parameter int PULSE_0        = 150_000,
  parameter int PULSE_POS90    = 200_000,
  parameter int SETTLE_PERIODS = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ENABLE,
  input  logic [1:0] grados,
  output logic       pwm,
  output logic       period_tick,
  output logic       ready
);

  localparam int CNT_W = $clog2(PERIOD_CYCLES);
  localparam int SET_W = $clog2(SETTLE_PERIODS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] W_NEG90     = CNT_W'(PULSE_NEG90);
  localparam logic [CNT_W-1:0] W_ZERO      = CNT_W'(PULSE_0);
  localparam logic [CNT_W-1:0] W_POS90     = CNT_W'(PULSE_POS90);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_PERIODS);
  localparam logic [SET_W-1:0] SETTLE_ONE  = SET_W'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             pwm_q, pwm_d;
  logic             tick_q, tick_d;
  logic             ready_q, ready_d;

  logic             pse;
  logic             from_idle;
  logic [CNT_W-1:0] new_width;

  // Code 3 (decoder error) falls back to the centre position.
  always_comb begin
    case (grados)
      2'd1:    new_width = W_POS90;
      2'd2:    new_width = W_NEG90;
      default: new_width = W_ZERO;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    width_d   = width_q;
    settle_d  = settle_q;
    ready_d   = ready_q;
    tick_d    = 1'b0;
    pse       = 1'b0;
    from_idle = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (ENABLE) begin
          pse       = 1'b1;
          from_idle = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          // ENABLE only matters here, so a mid-period drop still finishes
          // the current period cleanly.
          if (ENABLE) begin
            pse = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            ready_d  = 1'b0;
            settle_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (pse) begin
      cnt_d   = '0;
      width_d = new_width;
      tick_d  = 1'b1;
      // Settling restarts on entry or on a real width change; 0 <-> 3
      // produces the same width and therefore keeps counting.
      if (from_idle || (new_width != width_q)) begin
        settle_d = SETTLE_LOAD;
        ready_d  = 1'b0;
      end else if (settle_q > SETTLE_ONE) begin
        settle_d = settle_q - SETTLE_ONE;
      end else if (settle_q == SETTLE_ONE) begin
        settle_d = '0;
        ready_d  = 1'b1;
      end
    end

    // pwm is registered, so it is derived from next-cycle count and width:
    // high while the count of the upcoming cycle is below the latched width.
    pwm_d = (state_d == ST_RUN) && (cnt_d < width_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      width_q  <= W_ZERO;
      settle_q <= '0;
      pwm_q    <= 1'b0;
      tick_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      width_q  <= width_d;
      settle_q <= settle_d;
      pwm_q    <= pwm_d;
      tick_q   <= tick_d;
      ready_q  <= ready_d;
    end
  end

  assign pwm         = pwm_q;
  assign period_tick = tick_q;
  assign ready       = ready_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_servo_pwm_gen
//   Scoreboard bench for servo_pwm_gen. A reference model predicts one
//   transaction per period start (width, ready level, spacing to the previous
//   start) and queues it; a monitor pops one entry per observed period_tick,
//   then measures the pwm high run and tick spacing against it.
// -----------------------------------------------------------------------------
module tb_servo_pwm_gen;

  localparam int P  = 100;
  localparam int WN = 10;
  localparam int W0 = 15;
  localparam int WP = 20;
  localparam int S  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       ENABLE;
  logic [1:0] grados;
  logic       pwm;
  logic       period_tick;
  logic       ready;

  always #5 clk = ~clk;

  servo_pwm_gen #(
    .PERIOD_CYCLES (P),
    .PULSE_NEG90   (WN),
    .PULSE_0       (W0),
    .PULSE_POS90   (WP),
    .SETTLE_PERIODS(S)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ENABLE     (ENABLE),
    .grados     (grados),
    .pwm        (pwm),
    .period_tick(period_tick),
    .ready      (ready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int mcyc     = 0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, mcyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int w;
    bit rdy;
    int gap;   // expected ticks spacing, 0 = do not check (fresh start)
  } exp_t;

  exp_t sb_q[$];

  int n_edge    = 0;
  int pse_n     = 0;
  int cur_w     = W0;
  int same      = 0;   // unchanged periods completed since the last restart
  int rst_count = 0;
  bit running   = 1'b0;
  bit exp_ready = 1'b0;

  function automatic int width_of(input logic [1:0] g);
    int r;
    case (g)
      2'd1:    r = WP;
      2'd2:    r = WN;
      default: r = W0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    int  w;
    bit  cont;
    bit  do_pse;
    exp_t e;
    n_edge++;
    do_pse = 1'b0;
    cont   = 1'b0;
    if (reset) begin
      running   = 1'b0;
      exp_ready = 1'b0;
      same      = 0;
      rst_count++;
    end else if (!running) begin
      do_pse = ENABLE;
    end else if (n_edge - pse_n == P) begin
      if (ENABLE) begin
        do_pse = 1'b1;
        cont   = 1'b1;
      end else begin
        running   = 1'b0;
        exp_ready = 1'b0;
      end
    end
    if (do_pse) begin
      w = width_of(grados);
      if (!cont || w != cur_w) begin
        same      = 0;
        exp_ready = 1'b0;
      end else begin
        same++;
        if (same >= S) exp_ready = 1'b1;
      end
      cur_w   = w;
      running = 1'b1;
      pse_n   = n_edge;
      e.w     = w;
      e.rdy   = exp_ready;
      e.gap   = cont ? P : 0;
      sb_q.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  int   last_tick = 0;
  int   run_len   = 0;
  int   exp_w     = 0;
  int   seen_rst  = 0;
  bit   measuring = 1'b0;
  bit   prev_pwm  = 1'b0;
  exp_t tr;

  always @(negedge clk) begin
    mcyc++;
    if (rst_count != seen_rst) begin
      seen_rst  = rst_count;
      measuring = 1'b0;
      check(pwm === 1'b0, "reset_pwm", int'(pwm), 0);
      check(period_tick === 1'b0, "reset_tick", int'(period_tick), 0);
    end
    check(ready === exp_ready, "ready_level", int'(ready), int'(exp_ready));
    if (period_tick === 1'b1) begin
      if (measuring) check(run_len == exp_w, "width_overrun", run_len, exp_w);
      measuring = 1'b0;
      if (sb_q.size() == 0) begin
        check(1'b0, "unexpected_tick", 1, 0);
      end else begin
        tr = sb_q.pop_front();
        check(ready === tr.rdy, "tick_ready", int'(ready), int'(tr.rdy));
        if (tr.gap != 0) check(mcyc - last_tick == tr.gap, "period_len", mcyc - last_tick, tr.gap);
        exp_w     = tr.w;
        measuring = 1'b1;
        run_len   = 0;
      end
      last_tick = mcyc;
    end
    check(sb_q.size() == 0, "missing_tick", sb_q.size(), 0);
    sb_q.delete();
    if (pwm === 1'b1 && !prev_pwm) check(period_tick === 1'b1, "rise_with_tick", int'(period_tick), 1);
    if (measuring) begin
      if (pwm === 1'b1) begin
        run_len++;
      end else begin
        check(run_len == exp_w, "pulse_width", run_len, exp_w);
        measuring = 1'b0;
      end
    end
    prev_pwm = (pwm === 1'b1);
  end

  // ---------------- stimulus ----------------
  task automatic run(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Wait until the model says the counter is at phase k of a running period.
  task automatic wait_phase(input int k);
    int guard = 0;
    while (!(running && (n_edge - pse_n) == k) && guard < 3 * P) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check(guard < 3 * P, "wait_phase_timeout", guard, k);
  endtask

  initial begin
    int r;
    reset  = 1'b1;
    ENABLE = 1'b0;
    grados = 2'd0;
    run(5);
    reset  = 1'b0;
    ENABLE = 1'b1;
    run(320);

    // width change mid-period takes effect at the next start
    wait_phase(40); grados = 2'd1; run(300);
    wait_phase(40); grados = 2'd0; run(350);

    // 0 -> 3 keeps settling, 3 -> 2 restarts it
    wait_phase(40); grados = 2'd3; run(200);
    wait_phase(40); grados = 2'd2; run(150);

    // clean stop and restart
    wait_phase(5); ENABLE = 1'b0; run(150);
    ENABLE = 1'b1; run(250);

    // reset mid-pulse
    wait_phase(7); reset = 1'b1; run(1);
    reset = 1'b0; run(250);

    // ENABLE low only at the terminal count
    wait_phase(P - 1); ENABLE = 1'b0; run(1);
    ENABLE = 1'b1; run(300);

    // randomized traffic
    for (int i = 0; i < 50; i++) begin
      run($urandom_range(1, 250));
      r = $urandom_range(0, 99);
      if (r < 60) begin
        grados = 2'($urandom_range(0, 3));
      end else if (r < 85) begin
        ENABLE = ~ENABLE;
      end else if (r < 92) begin
        reset = 1'b1; run(1); reset = 1'b0;
      end
    end

    ENABLE = 1'b0;
    run(2 * P + 10);
    check(pwm === 1'b0, "final_pwm", int'(pwm), 0);
    check(ready === 1'b0, "final_ready", int'(ready), 0);
    check(!measuring, "final_measuring", int'(measuring), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
